// File: rtl/downscale_run_ctrl_pkg.sv
// Shared types and constants for the downscale run sequencer.
package downscale_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        RUN       = 3'd2,
        STEP_WAIT = 3'd3,
        DONE      = 3'd4,
        ABORT     = 3'd5
    } run_state_t;

    localparam logic MODE_SEQ  = 1'b0;
    localparam logic MODE_SIMD = 1'b1;

endpackage

// File: rtl/downscale_run_ctrl_if.sv
// Command, engine and status signals between the register bank, the engines and the run sequencer.
interface downscale_run_ctrl_if #(
    parameter int CNT_W = 32,
    parameter int PIX_W = 18
);
    logic             cmd_start;
    logic             cmd_step;
    logic             cmd_abort;
    logic             step_en;
    logic             mode_req;
    logic             cfg_we_in;
    logic             eng_pix_valid_seq;
    logic             eng_pix_valid_simd;
    logic             eng_done_seq;
    logic             eng_done_simd;
    logic             we_seq;
    logic             we_simd;
    logic             start_seq;
    logic             start_simd;
    logic             eng_hold;
    logic             eng_clr;
    logic             mode_active;
    logic             busy;
    logic             done_flag;
    logic             err_busy;
    logic             err_timeout;
    logic             aborted;
    logic [CNT_W-1:0] perf_cycles;
    logic [PIX_W-1:0] pix_count;

    modport slave (
        input  cmd_start, cmd_step, cmd_abort, step_en, mode_req, cfg_we_in,
        input  eng_pix_valid_seq, eng_pix_valid_simd, eng_done_seq, eng_done_simd,
        output we_seq, we_simd, start_seq, start_simd, eng_hold, eng_clr,
        output mode_active, busy, done_flag, err_busy, err_timeout, aborted,
        output perf_cycles, pix_count
    );

    modport master (
        output cmd_start, cmd_step, cmd_abort, step_en, mode_req, cfg_we_in,
        output eng_pix_valid_seq, eng_pix_valid_simd, eng_done_seq, eng_done_simd,
        input  we_seq, we_simd, start_seq, start_simd, eng_hold, eng_clr,
        input  mode_active, busy, done_flag, err_busy, err_timeout, aborted,
        input  perf_cycles, pix_count
    );

endinterface

// File: rtl/downscale_run_ctrl_watchdog.sv
// No-progress watchdog: counts enabled cycles since the last clear, flags expiry at TIMEOUT-1.
module run_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LIMIT = W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic ENABLED = (TIMEOUT != 0);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && ENABLED) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = ENABLED && en && (cnt == LIMIT);

endmodule

// File: rtl/downscale_run_ctrl.sv
// Run sequencer: routes start/load strobes to the selected downscale engine, handles
// single-step, abort and watchdog, and keeps the sticky status and performance counters.
module downscale_run_ctrl #(
    parameter int CNT_W   = 32,
    parameter int PIX_W   = 18,
    parameter int TIMEOUT = 4096
) (
    input logic                 clk,
    input logic                 rst,
    downscale_run_ctrl_if.slave bus
);
    import downscale_pkg::*;

    run_state_t       state;
    run_state_t       state_nx;
    logic             mode_q;
    logic             step_q;
    logic             pix;
    logic             done;
    logic             busy;
    logic             active;
    logic             in_run;
    logic             start_ok;
    logic             wd_clr;
    logic             wd_expire;
    logic             wd_fire;
    logic             done_flag_q;
    logic             err_busy_q;
    logic             err_timeout_q;
    logic             aborted_q;
    logic [CNT_W-1:0] perf_q;
    logic [PIX_W-1:0] pix_q;

    // Only the engine latched at start is listened to.
    assign pix  = (mode_q == MODE_SIMD) ? bus.eng_pix_valid_simd : bus.eng_pix_valid_seq;
    assign done = (mode_q == MODE_SIMD) ? bus.eng_done_simd : bus.eng_done_seq;

    assign busy     = (state != IDLE);
    assign active   = (state == LAUNCH) || (state == RUN) || (state == STEP_WAIT);
    assign in_run   = (state == RUN);
    assign start_ok = (state == IDLE) && bus.cmd_start;

    assign wd_clr  = (state == LAUNCH) || ((state == STEP_WAIT) && bus.cmd_step) || (active && pix);
    assign wd_fire = in_run && wd_expire && !pix && !done && !bus.cmd_abort;

    run_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (wd_clr),
        .en    (in_run),
        .expire(wd_expire)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (bus.cmd_start) state_nx = LAUNCH;
            LAUNCH:    state_nx = RUN;
            RUN: begin
                if (done)              state_nx = DONE;
                else if (pix && step_q) state_nx = STEP_WAIT;
                else if (wd_fire)      state_nx = ABORT;
            end
            STEP_WAIT: begin
                if (done)              state_nx = DONE;
                else if (bus.cmd_step) state_nx = RUN;
            end
            DONE:      state_nx = IDLE;
            ABORT:     state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        // Abort overrides any completion or step decision taken above.
        if (active && bus.cmd_abort) state_nx = ABORT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            mode_q        <= MODE_SEQ;
            step_q        <= 1'b0;
            done_flag_q   <= 1'b0;
            err_busy_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            aborted_q     <= 1'b0;
            perf_q        <= '0;
            pix_q         <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                mode_q        <= bus.mode_req;
                step_q        <= bus.step_en;
                done_flag_q   <= 1'b0;
                err_busy_q    <= 1'b0;
                err_timeout_q <= 1'b0;
                aborted_q     <= 1'b0;
                perf_q        <= '0;
                pix_q         <= '0;
            end else begin
                if (((state == LAUNCH) || in_run) && (perf_q != '1)) perf_q <= perf_q + 1'b1;
                if ((in_run || (state == STEP_WAIT)) && pix)          pix_q  <= pix_q + 1'b1;
                if (state == DONE)                                    done_flag_q   <= 1'b1;
                if (state == ABORT)                                   aborted_q     <= 1'b1;
                if (wd_fire)                                          err_timeout_q <= 1'b1;
                if (busy && (bus.cmd_start || bus.cfg_we_in))         err_busy_q    <= 1'b1;
            end
        end
    end

    // Load strobes follow the live mode request so images can be loaded before start.
    assign bus.we_seq  = bus.cfg_we_in && !busy && (bus.mode_req == MODE_SEQ);
    assign bus.we_simd = bus.cfg_we_in && !busy && (bus.mode_req == MODE_SIMD);

    assign bus.start_seq   = (state == LAUNCH) && (mode_q == MODE_SEQ);
    assign bus.start_simd  = (state == LAUNCH) && (mode_q == MODE_SIMD);
    assign bus.eng_hold    = (state == STEP_WAIT);
    assign bus.eng_clr     = (state == ABORT);
    assign bus.mode_active = mode_q;
    assign bus.busy        = busy;
    assign bus.done_flag   = done_flag_q;
    assign bus.err_busy    = err_busy_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.aborted     = aborted_q;
    assign bus.perf_cycles = perf_q;
    assign bus.pix_count   = pix_q;

endmodule

// File: tb/tb_downscale_run_ctrl.sv
// Scoreboard bench for downscale_run_ctrl: directed runs push expected start/end events,
// a negedge monitor pops and compares them when the DUT pulses start or drops busy.
module tb_downscale_run_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    downscale_run_ctrl_if #(.CNT_W(32), .PIX_W(18)) bus ();
    downscale_run_ctrl_if #(.CNT_W(4),  .PIX_W(18)) bus0 ();

    downscale_run_ctrl #(.CNT_W(32), .PIX_W(18), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    downscale_run_ctrl #(.CNT_W(4), .PIX_W(18), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );

    typedef struct {
        bit         is_end;
        logic [1:0] starts;
        logic       done, abt, tmo, ebusy, mode;
        int         pix, perf, clrs;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void exp_start(input bit simd);
        exp_t e;
        e        = '{default: 0};
        e.is_end = 1'b0;
        e.starts = simd ? 2'b01 : 2'b10;
        q.push_back(e);
    endfunction

    function automatic void exp_end(input bit done, abt, tmo, ebusy, mode, input int pix, perf, clrs);
        exp_t e;
        e        = '{default: 0};
        e.is_end = 1'b1;
        e.done = done; e.abt = abt; e.tmo = tmo; e.ebusy = ebusy; e.mode = mode;
        e.pix  = pix;  e.perf = perf; e.clrs = clrs;
        q.push_back(e);
    endfunction

    // Monitor: compares at each start pulse and at each busy falling edge.
    logic prev_busy = 1'b0;
    int   clr_seen  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.eng_clr) clr_seen++;
        if (bus.start_seq || bus.start_simd) begin
            if (q.size() == 0 || q[0].is_end) begin
                n_cmp++; n_bad++;
                $display("FAIL start_event: unexpected start seq=%0b simd=%0b (t=%0t)",
                         bus.start_seq, bus.start_simd, $time);
            end else begin
                e = q.pop_front();
                chk("start_sel", {bus.start_seq, bus.start_simd}, e.starts);
            end
            clr_seen = 0;
        end
        if (prev_busy && !bus.busy) begin
            if (q.size() == 0 || !q[0].is_end) begin
                n_cmp++; n_bad++;
                $display("FAIL end_event: unexpected end of run (t=%0t)", $time);
            end else begin
                e = q.pop_front();
                chk("end_done_flag",   bus.done_flag,   e.done);
                chk("end_aborted",     bus.aborted,     e.abt);
                chk("end_err_timeout", bus.err_timeout, e.tmo);
                chk("end_err_busy",    bus.err_busy,    e.ebusy);
                chk("end_mode_active", bus.mode_active, e.mode);
                chk("end_pix_count",   bus.pix_count,   e.pix);
                chk("end_perf_cycles", bus.perf_cycles, e.perf);
                chk("end_eng_clr_cyc", clr_seen,        e.clrs);
            end
        end
        prev_busy = bus.busy;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_in();
        bus.cmd_start = 0; bus.cmd_step = 0; bus.cmd_abort = 0;
        bus.cfg_we_in = 0;
        bus.eng_pix_valid_seq = 0; bus.eng_pix_valid_simd = 0;
        bus.eng_done_seq = 0; bus.eng_done_simd = 0;
    endtask

    // Issues cmd_start and returns in the first RUN cycle.
    task automatic launch(input bit mode, input bit step);
        bus.mode_req  = mode;
        bus.step_en   = step;
        bus.cmd_start = 1;
        exp_start(mode);
        tick();
        bus.cmd_start = 0;
        chk("launch_busy",      bus.busy,      1);
        chk("launch_err_clr",   bus.err_busy,  0);
        chk("launch_done_clr",  bus.done_flag, 0);
        tick();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 50) begin
            tick();
            n++;
        end
        chk(name, bus.busy, 0);
    endtask

    task automatic run_seq_normal();
        launch(0, 0);
        exp_end(1, 0, 0, 0, 0, 5, 21, 0);
        for (int c = 1; c <= 20; c++) begin
            bus.eng_pix_valid_seq = ((c % 3) == 2) && (c <= 14);
            bus.eng_done_seq      = (c == 20);
            tick();
        end
        clr_in();
        wait_idle("seq_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr_in();
        bus.mode_req = 0; bus.step_en = 0;
        bus0.cmd_start = 0; bus0.cmd_step = 0; bus0.cmd_abort = 0; bus0.cfg_we_in = 0;
        bus0.step_en = 0; bus0.mode_req = 0;
        bus0.eng_pix_valid_seq = 0; bus0.eng_pix_valid_simd = 0;
        bus0.eng_done_seq = 0; bus0.eng_done_simd = 0;

        // Reset state, observed before any clock edge.
        #3;
        chk("rst_flags", {bus.busy, bus.start_seq, bus.start_simd, bus.eng_hold, bus.eng_clr,
                          bus.mode_active, bus.done_flag, bus.err_busy, bus.err_timeout,
                          bus.aborted, bus.we_seq, bus.we_simd}, 0);
        chk("rst_counts", {bus.perf_cycles, bus.pix_count}, 0);
        tick(2);
        rst = 0;
        tick();

        // Sequential normal run.
        run_seq_normal();

        // SIMD step mode; inactive-engine strobes and a stray step are ignored.
        launch(1, 1);
        bus.eng_pix_valid_seq = 1; bus.eng_done_seq = 1; bus.cmd_step = 1;
        tick();
        clr_in();
        tick();
        bus.eng_pix_valid_simd = 1;
        tick();
        clr_in();
        chk("step_hold",      bus.eng_hold,    1);
        chk("step_perf",      bus.perf_cycles, 4);
        tick(5);
        chk("step_hold_kept", bus.eng_hold,    1);
        chk("step_perf_frz",  bus.perf_cycles, 4);
        exp_end(1, 0, 0, 0, 1, 4, 7, 0);
        for (int s = 1; s <= 3; s++) begin
            bus.cmd_step = 1;
            tick();
            bus.cmd_step = 0;
            chk("step_released", bus.eng_hold, 0);
            bus.eng_pix_valid_simd = 1;
            bus.eng_done_simd      = (s == 3);
            tick();
            clr_in();
            if (s < 3) chk("step_rehold", bus.eng_hold, 1);
        end
        wait_idle("simd_idle");

        // Write gating while idle follows the live mode request.
        bus.cfg_we_in = 1; bus.mode_req = 0;
        #1;
        chk("we_idle_seq", {bus.we_seq, bus.we_simd}, 2'b10);
        bus.mode_req = 1;
        #1;
        chk("we_idle_simd", {bus.we_seq, bus.we_simd}, 2'b01);
        bus.cfg_we_in = 0;

        // Busy protection.
        launch(0, 0);
        tick();
        bus.cmd_start = 1; bus.cfg_we_in = 1;
        #1;
        chk("we_busy", {bus.we_seq, bus.we_simd}, 2'b00);
        tick();
        clr_in();
        chk("err_busy_set", bus.err_busy, 1);
        tick();
        exp_end(1, 0, 0, 1, 0, 0, 5, 0);
        bus.eng_done_seq = 1;
        tick();
        clr_in();
        wait_idle("busy_idle");

        // Abort in IDLE is ignored.
        bus.cmd_abort = 1;
        tick();
        bus.cmd_abort = 0;
        chk("idle_abort_busy", bus.busy,      0);
        chk("idle_abort_flag", bus.aborted,   0);
        chk("idle_abort_done", bus.done_flag, 1);

        // Abort coincident with done and a pixel.
        launch(0, 0);
        exp_end(0, 1, 0, 0, 0, 1, 4, 1);
        tick(2);
        bus.eng_pix_valid_seq = 1; bus.eng_done_seq = 1; bus.cmd_abort = 1;
        tick();
        clr_in();
        chk("abort_clr", bus.eng_clr, 1);
        wait_idle("abort_idle");

        // Watchdog with TIMEOUT=16 and a silent engine.
        launch(0, 0);
        exp_end(0, 1, 1, 0, 0, 0, 17, 1);
        tick(15);
        chk("wd_run16_busy", bus.busy,    1);
        chk("wd_run16_clr",  bus.eng_clr, 0);
        tick();
        chk("wd_abort_clr",  bus.eng_clr, 1);
        wait_idle("wd_idle");

        // Watchdog disabled: run persists, 4-bit perf counter saturates.
        bus0.cmd_start = 1;
        tick();
        bus0.cmd_start = 0;
        tick(100);
        chk("wd0_busy",    bus0.busy,        1);
        chk("wd0_aborted", bus0.aborted,     0);
        chk("wd0_perf_sat", bus0.perf_cycles, 4'hF);
        bus0.cmd_abort = 1;
        tick();
        bus0.cmd_abort = 0;
        tick();
        chk("wd0_abort_done", {bus0.busy, bus0.aborted}, 2'b01);

        // Asynchronous reset while holding in STEP_WAIT.
        launch(1, 1);
        bus.eng_pix_valid_simd = 1;
        tick();
        clr_in();
        chk("pre_rst_hold", bus.eng_hold,  1);
        chk("pre_rst_pix",  bus.pix_count, 1);
        exp_end(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1;
        #1;
        chk("async_rst_flags", {bus.busy, bus.start_seq, bus.start_simd, bus.eng_hold,
                                bus.eng_clr, bus.mode_active, bus.done_flag, bus.err_busy,
                                bus.err_timeout, bus.aborted}, 0);
        chk("async_rst_counts", {bus.perf_cycles, bus.pix_count}, 0);
        tick();
        rst = 0;
        tick();
        run_seq_normal();

        tick(3);
        chk("sb_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/downscale_run_ctrl.md
Name: downscale_run_ctrl

Overview:
- Run sequencer between the JTAG register bank and the two downscale engines (sequential, SIMD).
- Latches the engine select at start and routes image-load write strobes and the start pulse to the selected engine. Nothing is routed while a run is busy.
- Provides single-step (pixel-by-pixel) execution, abort, and a no-progress watchdog.
- Maintains the sticky done/error flags, the cycle counter and the output-pixel counter read back over JTAG.

Parameters:
- CNT_W, 32, width of perf_cycles (saturating).
- PIX_W, 18, width of pix_count; must hold DST_W*DST_H (256*256 = 65536).
- TIMEOUT, 4096, RUN cycles without eng_pix_valid before watchdog abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cmd_start  in  1  1-cycle start pulse from register bank
- cmd_step  in  1  1-cycle step pulse
- cmd_abort  in  1  1-cycle abort pulse
- step_en  in  1  step mode request, sampled at start
- mode_req  in  1  0=sequential, 1=SIMD, sampled at start
- cfg_we_in  in  1  image-load write strobe from register bank
- eng_pix_valid_seq / eng_pix_valid_simd  in  1 each  engine wrote one output pixel
- eng_done_seq / eng_done_simd  in  1 each  engine finished
- we_seq / we_simd  out  1 each  gated write strobes
- start_seq / start_simd  out  1 each  1-cycle engine start
- eng_hold  out  1  freezes the active engine
- eng_clr  out  1  1-cycle synchronous clear to both engines
- mode_active  out  1  latched mode
- busy  out  1  run in progress
- done_flag  out  1  sticky, run completed
- err_busy  out  1  sticky, start or load attempted while busy
- err_timeout  out  1  sticky, watchdog fired
- aborted  out  1  sticky, run ended by abort or watchdog
- perf_cycles  out  CNT_W  active run cycles
- pix_count  out  PIX_W  output pixels produced

Behaviour:
- Reset rst is asynchronous, active-high; clock clk.
- During reset, all outputs are 0 and state is IDLE.
- States and per-cycle actions (all outputs registered/Moore):
  - IDLE: busy=0.
  - LAUNCH: start_<mode_active>=1 for exactly one cycle; busy=1.
  - RUN: busy=1.
  - STEP_WAIT: eng_hold=1, busy=1.
  - DONE: one cycle.
  - ABORT: one cycle, eng_clr=1.
- IDLE, cmd_start at cycle t:
  - Latch mode_req and step_en; clear done_flag, err_busy, err_timeout, aborted, perf_cycles, pix_count.
  - State LAUNCH in t+1, so the start pulse is seen in cycle t+1.
- LAUNCH -> RUN unconditionally.
- Inputs from the inactive engine are ignored throughout.
- RUN, evaluated each cycle:
  - eng_done -> DONE. If eng_pix_valid in the same cycle, pix_count still increments.
  - Else eng_pix_valid with step mode latched -> STEP_WAIT. eng_hold asserts from the next cycle; the engine must tolerate one extra cycle of progress.
  - Else watchdog expiry -> ABORT with err_timeout=1.
- STEP_WAIT:
  - cmd_step -> RUN.
  - Watchdog counter is frozen.
  - eng_done while holding -> DONE.
- DONE: done_flag<=1 -> IDLE.
- ABORT: aborted<=1, eng_clr=1 -> IDLE. done_flag stays 0.
- cmd_abort in LAUNCH/RUN/STEP_WAIT -> ABORT. Abort has priority over done/pix in the same cycle, but pix_count still counts a coincident pixel. cmd_abort in IDLE is ignored.
- cmd_start while not IDLE: ignored, err_busy<=1.
- cmd_step outside STEP_WAIT: ignored, no error.
- Write gating:
  - we_seq = cfg_we_in & ~busy & ~mode_req; we_simd = cfg_we_in & ~busy & mode_req. Combinational, zero latency, so loads follow the live mode_req.
  - cfg_we_in while busy: dropped, err_busy<=1.
- perf_cycles: +1 in every LAUNCH and RUN cycle; not in STEP_WAIT. Saturates at all-ones.
- pix_count: +1 per eng_pix_valid of the active engine in RUN/STEP_WAIT. Wraps modulo 2^PIX_W (sized so this does not occur).
- Watchdog:
  - Counter cleared on entering RUN and on each eng_pix_valid.
  - Increments in RUN; expires when it reaches TIMEOUT-1 with no pix_valid that cycle.
- Reset mid-run: immediate return to IDLE with all flags cleared. No eng_clr pulse (the engines share rst).

Decomposition:
- Shared package downscale_pkg:
  - state enum run_state_t {IDLE, LAUNCH, RUN, STEP_WAIT, DONE, ABORT}.
  - constants MODE_SEQ=0, MODE_SIMD=1.
- One sub-module, run_watchdog: TIMEOUT counter with clear/enable/expire ports.

Test Plan:
- Sequential normal run: mode_req=0, step_en=0, cmd_start; engine gives 5 pix_valid then done at the 20th RUN cycle.
  -> start_seq high 1 cycle at t+1, start_simd never high.
  -> pix_count=5, perf_cycles=21, done_flag=1, busy=0.
- SIMD step mode: mode_req=1, step_en=1; engine pulses pix_valid on the 3rd RUN cycle.
  -> eng_hold=1 from the next cycle until cmd_step; perf_cycles does not advance while held.
  -> after 3 steps and done: pix_count=4, done_flag=1.
- Busy protection: cmd_start and cfg_we_in during RUN.
  -> no second start pulse, we_seq/we_simd stay 0, err_busy=1.
  -> next accepted cmd_start clears err_busy.
- Abort coincident with done: cmd_abort and eng_done in the same RUN cycle.
  -> ABORT taken, eng_clr 1 cycle, aborted=1, done_flag=0.
- Watchdog: TIMEOUT=16, engine silent after start.
  -> ABORT after 16 RUN cycles, err_timeout=1, aborted=1, perf_cycles=17.
  -> with TIMEOUT=0 the run stays in RUN indefinitely.
- Async reset in STEP_WAIT.
  -> all outputs 0 immediately, state IDLE.
  -> a subsequent run behaves identically to the first scenario.
